// File: rtl/ping_ranger.sv
// PING))) ultrasound ranger: triggers the sensor, times the echo, and
// publishes a saturating cm distance with a one-cycle start strobe.
// Ports: clk, rst_n (async low), enable, ping_in (async pin read),
//        ping_out/ping_oe (pin drive), d[6:0], start, timeout, busy.
module ping_ranger #(
  parameter int unsigned TRIG_CYC    = 250,
  parameter int unsigned HOLDOFF_CYC = 37500,
  parameter int unsigned CYC_PER_CM  = 2900,
  parameter int unsigned TIMEOUT_CYC = 925000,
  parameter int unsigned REST_CYC    = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ping_in,
  output logic       ping_out,
  output logic       ping_oe,
  output logic [6:0] d,
  output logic       start,
  output logic       timeout,
  output logic       busy
);

  localparam int CNT_W = 20;
  localparam int SUB_W =
    ($clog2(CYC_PER_CM) < 1) ? 1 : $clog2(CYC_PER_CM);

  localparam logic [CNT_W-1:0] L_TRIG =
    CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD =
    CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] L_TOUT =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] L_REST =
    CNT_W'(REST_CYC - 1);
  localparam logic [SUB_W-1:0] L_SUB =
    SUB_W'(CYC_PER_CM - 1);
  localparam logic [6:0] CM_MAX = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_HOLD,
    S_WAIT,
    S_MEAS,
    S_DONE,
    S_TOUT,
    S_REST
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_echo;
  logic [CNT_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic [6:0]       r_cm;
  logic [6:0]       r_d;
  logic             r_timeout;

  logic [SUB_W-1:0] w_sub_cur;
  logic [6:0]       w_cm_cur;
  logic [SUB_W-1:0] w_sub_nxt;
  logic [6:0]       w_cm_nxt;
  logic             w_count;

  assign w_echo = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ping_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (enable) w_next = S_TRIG;
      S_TRIG: if (r_cnt == L_TRIG) w_next = S_HOLD;
      S_HOLD: if (r_cnt == L_HOLD) w_next = S_WAIT;
      S_WAIT: begin
        if (w_echo) w_next = S_MEAS;
        else if (r_cnt == L_TOUT) w_next = S_TOUT;
      end
      S_MEAS: begin
        if (!w_echo) w_next = S_DONE;
        else if (r_cnt == L_TOUT) w_next = S_TOUT;
      end
      S_DONE: w_next = S_REST;
      S_TOUT: w_next = S_REST;
      S_REST: begin
        if (r_cnt == L_REST)
          w_next = enable ? S_TRIG : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The rising cycle seen in WAIT counts as the first echo-high cycle,
  // so accumulation starts from zero there and continues in MEAS.
  always_comb begin
    w_count   = w_echo &&
                (r_state == S_WAIT || r_state == S_MEAS);
    w_sub_cur = (r_state == S_MEAS) ? r_sub : '0;
    w_cm_cur  = (r_state == S_MEAS) ? r_cm : '0;
    w_sub_nxt = w_sub_cur + 1'b1;
    w_cm_nxt  = w_cm_cur;
    if (w_sub_cur == L_SUB) begin
      w_sub_nxt = '0;
      if (w_cm_cur != CM_MAX) w_cm_nxt = w_cm_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= '0;
      r_cm  <= '0;
    end else if (w_count) begin
      r_sub <= w_sub_nxt;
      r_cm  <= w_cm_nxt;
    end
  end

  // Result is loaded on entry to DONE/TOUT so d is already valid
  // during the start cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d       <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_MEAS && w_next == S_DONE) begin
      r_d       <= r_cm;
      r_timeout <= 1'b0;
    end else if (r_state != S_TOUT && w_next == S_TOUT) begin
      r_d       <= CM_MAX;
      r_timeout <= 1'b1;
    end
  end

  always_comb begin
    ping_oe  = 1'b0;
    ping_out = 1'b0;
    start    = 1'b0;
    busy     = (r_state != S_IDLE);
    if (r_state == S_TRIG) begin
      ping_oe  = 1'b1;
      ping_out = 1'b1;
    end
    if (r_state == S_DONE || r_state == S_TOUT)
      start = 1'b1;
  end

  assign d       = r_d;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_ping_ranger.sv
// Directed bench for ping_ranger with shortened timing parameters.
// Each task drives one scenario and checks against hand-derived values.
module tb_ping_ranger;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       ping_in;
  logic       ping_out;
  logic       ping_oe;
  logic [6:0] d;
  logic       start;
  logic       timeout;
  logic       busy;

  int checks;
  int errors;

  ping_ranger #(
    .TRIG_CYC(4),
    .HOLDOFF_CYC(8),
    .CYC_PER_CM(10),
    .TIMEOUT_CYC(2000),
    .REST_CYC(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .ping_in(ping_in),
    .ping_out(ping_out),
    .ping_oe(ping_oe),
    .d(d),
    .start(start),
    .timeout(timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the first negedge with ping_oe low after a trigger.
  task automatic wait_trig_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ping_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!ping_oe) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_echo(input int n, input int exp_d,
                          input int drop_at,
                          input string name);
    bit ok;
    int extra;
    wait_trig_end(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s trigger: not seen", name);
      return;
    end
    repeat (10) @(negedge clk);
    ping_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) enable = 1'b0;
      @(negedge clk);
    end
    ping_in = 1'b0;
    wait_start(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s start: not seen", name);
      return;
    end
    checks++;
    if (d !== 7'(exp_d)) begin
      errors++;
      $display("FAIL %s d: got %0d want %0d", name, d, exp_d);
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: got %b want 0", name, timeout);
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s extra_start: got %0d want 0", name, extra);
    end
  endtask

  task automatic test_reset();
    bit exp;
    rst_n   = 1'b1;
    enable  = 1'b0;
    ping_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ping_out, ping_oe, start, timeout, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rst_outs: got %b want 00000",
               {ping_out, ping_oe, start, timeout, busy});
    end
    checks++;
    if (d !== 7'd0) begin
      errors++;
      $display("FAIL rst_d: got %0d want 0", d);
    end
    enable = 1'b1;
    rst_n  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp = (i <= 4);
      checks++;
      if (ping_oe !== exp || ping_out !== exp) begin
        errors++;
        $display("FAIL trig_c%0d: oe=%b out=%b want %b",
                 i, ping_oe, ping_out, exp);
      end
      checks++;
      if (start !== 1'b0 || d !== 7'd0) begin
        errors++;
        $display("FAIL trig_quiet_c%0d: start=%b d=%0d want 0/0",
                 i, start, d);
      end
    end
  endtask

  task automatic test_nominal();
    run_echo(250, 25, -1, "echo250");
    run_echo(249, 24, -1, "echo249");
  endtask

  task automatic test_saturation();
    run_echo(1500, 127, -1, "echo1500");
  endtask

  task automatic test_no_echo();
    bit ok;
    int k;
    wait_trig_end(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL noecho trigger: not seen");
      return;
    end
    ping_in = 1'b0;
    k = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (start) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k !== 2008) begin
      errors++;
      $display("FAIL noecho_latency: got %0d want 2008", k);
    end
    checks++;
    if (d !== 7'd127 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL noecho_result: d=%0d to=%b want 127/1",
               d, timeout);
    end
    run_echo(50, 5, -1, "echo50_after_to");
  endtask

  task automatic test_enable_drop();
    int oe_n;
    int busy_n;
    run_echo(100, 10, 50, "echo100_drop");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy: got %b want 0", busy);
    end
    oe_n   = 0;
    busy_n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ping_oe) oe_n++;
      if (busy) busy_n++;
    end
    checks++;
    if (oe_n !== 0 || busy_n !== 0) begin
      errors++;
      $display("FAIL drop_park: oe=%0d busy=%0d want 0/0",
               oe_n, busy_n);
    end
  endtask

  task automatic test_async_reset();
    int oe_n;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (ping_oe !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre_oe: got %b want 1", ping_oe);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ping_oe !== 1'b0 || ping_out !== 1'b0) begin
      errors++;
      $display("FAIL arst_pin: oe=%b out=%b want 0/0",
               ping_oe, ping_out);
    end
    checks++;
    if (d !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_state: d=%0d busy=%b want 0/0", d, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ping_oe !== 1'b1) begin
      errors++;
      $display("FAIL arst_recover_oe: got %b want 1", ping_oe);
    end
    oe_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ping_oe) oe_n++;
    end
    checks++;
    if (oe_n !== 4) begin
      errors++;
      $display("FAIL arst_recover_width: got %0d want 4", oe_n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nominal();
    test_saturation();
    test_no_echo();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
